// File: rtl/phys_reg_map_rollback_ctrl.sv
// phys_reg_map_rollback_ctrl
// Drives map-table recovery after branch resolution. On a mispredict it
// restores the branch's checkpoint column when one exists. It then walks the
// ROB from youngest to oldest, reverting mappings when the restore did not
// happen. It also frees each speculated physical register and finally rolls
// back the ROB tail. On a correct resolution it invalidates the branch's
// checkpoint column. Dispatch is stalled through busy while any of this runs.
module phys_reg_map_rollback_ctrl #(
  parameter int LOG_ROB_DEPTH          = 6,
  parameter int LOG_CHECKPOINT_COLUMNS = 2,
  parameter int LOG_NUM_ARCH_REGS      = 5,
  parameter int LOG_NUM_PHYS_REGS      = 6
) (
  input  logic                              CLK,
  input  logic                              RST,

  // branch mispredict
  input  logic                              mispredict_valid,
  output logic                              mispredict_ready,
  input  logic [LOG_ROB_DEPTH-1:0]          mispredict_ROB_index,
  input  logic                              mispredict_checkpoint_valid,
  input  logic [LOG_CHECKPOINT_COLUMNS-1:0] mispredict_checkpoint_column,

  // correct branch resolution
  input  logic                              resolve_valid,
  output logic                              resolve_ready,
  input  logic [LOG_ROB_DEPTH-1:0]          resolve_ROB_index,
  input  logic [LOG_CHECKPOINT_COLUMNS-1:0] resolve_checkpoint_column,

  // ROB tail and same-cycle read port
  input  logic [LOG_ROB_DEPTH-1:0]          rob_tail_index,
  output logic [LOG_ROB_DEPTH-1:0]          rob_read_index,
  input  logic                              rob_read_has_dest,
  input  logic [LOG_NUM_ARCH_REGS-1:0]      rob_read_arch_reg_tag,
  input  logic [LOG_NUM_PHYS_REGS-1:0]      rob_read_safe_phys_reg_tag,
  input  logic [LOG_NUM_PHYS_REGS-1:0]      rob_read_spec_phys_reg_tag,

  // map table revert
  output logic                              revert_valid,
  output logic [LOG_NUM_ARCH_REGS-1:0]      revert_dest_arch_reg_tag,
  output logic [LOG_NUM_PHYS_REGS-1:0]      revert_safe_dest_phys_reg_tag,
  output logic [LOG_NUM_PHYS_REGS-1:0]      revert_speculated_dest_phys_reg_tag,

  // map table checkpoint restore / invalidate
  output logic                              restore_checkpoint_valid,
  output logic                              restore_checkpoint_speculate_failed,
  output logic [LOG_ROB_DEPTH-1:0]          restore_checkpoint_ROB_index,
  output logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_checkpoint_safe_column,
  input  logic                              restore_checkpoint_success,

  // free list
  output logic                              free_list_push_valid,
  output logic [LOG_NUM_PHYS_REGS-1:0]      free_list_push_tag,

  // ROB tail rollback
  output logic                              rob_rollback_valid,
  output logic [LOG_ROB_DEPTH-1:0]          rob_rollback_tail_index,

  output logic                              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INVAL   = 3'd1,
    RESTORE = 3'd2,
    WALK    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [LOG_ROB_DEPTH-1:0] ROB_ZERO = {LOG_ROB_DEPTH{1'b0}};
  localparam logic [LOG_ROB_DEPTH-1:0] ROB_ONE  = {{(LOG_ROB_DEPTH-1){1'b0}}, 1'b1};

  state_t                              state_r;
  logic [LOG_ROB_DEPTH-1:0]            branch_index_r;
  logic [LOG_ROB_DEPTH-1:0]            walk_ptr_r;
  logic [LOG_ROB_DEPTH-1:0]            walk_count_r;
  logic                                restored_r;

  // State-only handshake outputs are computed from the next state, so they
  // come straight out of flops.
  logic                                busy_r;
  logic                                restore_valid_r;
  logic                                restore_failed_r;
  logic [LOG_ROB_DEPTH-1:0]            restore_index_r;
  logic [LOG_CHECKPOINT_COLUMNS-1:0]   restore_column_r;
  logic                                rollback_valid_r;
  logic [LOG_ROB_DEPTH-1:0]            rollback_tail_r;

  // Number of entries younger than the branch. Modulo arithmetic makes a full
  // ROB (tail == branch) come out as depth - 1.
  logic [LOG_ROB_DEPTH-1:0]            walk_count_init_s;
  logic                                idle_s;

  assign walk_count_init_s = rob_tail_index - mispredict_ROB_index - ROB_ONE;
  assign idle_s            = (state_r == IDLE);

  // Handshake readiness: only idle accepts, and a mispredict beats a resolve.
  always_comb begin
    mispredict_ready = 1'b0;
    resolve_ready    = 1'b0;
    if (idle_s) begin
      mispredict_ready = 1'b1;
      resolve_ready    = ~mispredict_valid;
    end else begin
      mispredict_ready = 1'b0;
      resolve_ready    = 1'b0;
    end
  end

  // Recovery FSM: sequencing, walk bookkeeping and the registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r          <= IDLE;
      branch_index_r   <= {LOG_ROB_DEPTH{1'b0}};
      walk_ptr_r       <= {LOG_ROB_DEPTH{1'b0}};
      walk_count_r     <= {LOG_ROB_DEPTH{1'b0}};
      restored_r       <= 1'b0;
      busy_r           <= 1'b0;
      restore_valid_r  <= 1'b0;
      restore_failed_r <= 1'b0;
      restore_index_r  <= {LOG_ROB_DEPTH{1'b0}};
      restore_column_r <= {LOG_CHECKPOINT_COLUMNS{1'b0}};
      rollback_valid_r <= 1'b0;
      rollback_tail_r  <= {LOG_ROB_DEPTH{1'b0}};
    end else begin
      busy_r           <= 1'b0;
      restore_valid_r  <= 1'b0;
      restore_failed_r <= 1'b0;
      restore_index_r  <= {LOG_ROB_DEPTH{1'b0}};
      restore_column_r <= {LOG_CHECKPOINT_COLUMNS{1'b0}};
      rollback_valid_r <= 1'b0;
      rollback_tail_r  <= {LOG_ROB_DEPTH{1'b0}};
      case (state_r)
        IDLE: begin
          if (mispredict_valid) begin
            branch_index_r <= mispredict_ROB_index;
            walk_count_r   <= walk_count_init_s;
            walk_ptr_r     <= rob_tail_index - ROB_ONE;
            restored_r     <= 1'b0;
            busy_r         <= 1'b1;
            if (mispredict_checkpoint_valid) begin
              state_r          <= RESTORE;
              restore_valid_r  <= 1'b1;
              restore_failed_r <= 1'b1;
              restore_index_r  <= mispredict_ROB_index;
              restore_column_r <= mispredict_checkpoint_column;
            end else if (walk_count_init_s == ROB_ZERO) begin
              state_r          <= DONE;
              rollback_valid_r <= 1'b1;
              rollback_tail_r  <= mispredict_ROB_index + ROB_ONE;
            end else begin
              state_r <= WALK;
            end
          end else if (resolve_valid) begin
            state_r          <= INVAL;
            busy_r           <= 1'b1;
            restore_valid_r  <= 1'b1;
            restore_failed_r <= 1'b0;
            restore_index_r  <= resolve_ROB_index;
            restore_column_r <= resolve_checkpoint_column;
          end else begin
            state_r <= IDLE;
          end
        end
        INVAL: begin
          // The map table's success flag is irrelevant for an invalidate.
          state_r <= IDLE;
        end
        RESTORE: begin
          restored_r <= restore_checkpoint_success;
          busy_r     <= 1'b1;
          if (walk_count_r == ROB_ZERO) begin
            state_r          <= DONE;
            rollback_valid_r <= 1'b1;
            rollback_tail_r  <= branch_index_r + ROB_ONE;
          end else begin
            state_r <= WALK;
          end
        end
        WALK: begin
          busy_r       <= 1'b1;
          walk_ptr_r   <= walk_ptr_r - ROB_ONE;
          walk_count_r <= walk_count_r - ROB_ONE;
          if (walk_count_r == ROB_ONE) begin
            state_r          <= DONE;
            rollback_valid_r <= 1'b1;
            rollback_tail_r  <= branch_index_r + ROB_ONE;
          end else begin
            state_r <= WALK;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy                                = busy_r;
  assign restore_checkpoint_valid            = restore_valid_r;
  assign restore_checkpoint_speculate_failed = restore_failed_r;
  assign restore_checkpoint_ROB_index        = restore_index_r;
  assign restore_checkpoint_safe_column      = restore_column_r;
  assign rob_rollback_valid                  = rollback_valid_r;
  assign rob_rollback_tail_index             = rollback_tail_r;

  // Walk datapath: ROB read data is same-cycle, so revert and free pushes
  // are formed combinationally from the entry under walk_ptr.
  always_comb begin
    rob_read_index                      = {LOG_ROB_DEPTH{1'b0}};
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = {LOG_NUM_ARCH_REGS{1'b0}};
    revert_safe_dest_phys_reg_tag       = {LOG_NUM_PHYS_REGS{1'b0}};
    revert_speculated_dest_phys_reg_tag = {LOG_NUM_PHYS_REGS{1'b0}};
    free_list_push_valid                = 1'b0;
    free_list_push_tag                  = {LOG_NUM_PHYS_REGS{1'b0}};
    if (state_r == WALK) begin
      rob_read_index = walk_ptr_r;
      if (rob_read_has_dest) begin
        // The speculated register is freed whether or not the map table
        // was recovered from a checkpoint.
        free_list_push_valid = 1'b1;
        free_list_push_tag   = rob_read_spec_phys_reg_tag;
        if (!restored_r) begin
          revert_valid                        = 1'b1;
          revert_dest_arch_reg_tag            = rob_read_arch_reg_tag;
          revert_safe_dest_phys_reg_tag       = rob_read_safe_phys_reg_tag;
          revert_speculated_dest_phys_reg_tag = rob_read_spec_phys_reg_tag;
        end else begin
          revert_valid = 1'b0;
        end
      end else begin
        free_list_push_valid = 1'b0;
      end
    end else begin
      rob_read_index = {LOG_ROB_DEPTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_phys_reg_map_rollback_ctrl.sv
// Bench for phys_reg_map_rollback_ctrl: per-cycle directed vectors from a
// table, plus hand-written sequences for full-ROB walk and reset mid-walk.
module tb_phys_reg_map_rollback_ctrl;

  logic       CLK;
  logic       RST;
  logic       mispredict_valid;
  logic       mispredict_ready;
  logic [5:0] mispredict_ROB_index;
  logic       mispredict_checkpoint_valid;
  logic [1:0] mispredict_checkpoint_column;
  logic       resolve_valid;
  logic       resolve_ready;
  logic [5:0] resolve_ROB_index;
  logic [1:0] resolve_checkpoint_column;
  logic [5:0] rob_tail_index;
  logic [5:0] rob_read_index;
  logic       rob_read_has_dest;
  logic [4:0] rob_read_arch_reg_tag;
  logic [5:0] rob_read_safe_phys_reg_tag;
  logic [5:0] rob_read_spec_phys_reg_tag;
  logic       revert_valid;
  logic [4:0] revert_dest_arch_reg_tag;
  logic [5:0] revert_safe_dest_phys_reg_tag;
  logic [5:0] revert_speculated_dest_phys_reg_tag;
  logic       restore_checkpoint_valid;
  logic       restore_checkpoint_speculate_failed;
  logic [5:0] restore_checkpoint_ROB_index;
  logic [1:0] restore_checkpoint_safe_column;
  logic       restore_checkpoint_success;
  logic       free_list_push_valid;
  logic [5:0] free_list_push_tag;
  logic       rob_rollback_valid;
  logic [5:0] rob_rollback_tail_index;
  logic       busy;

  phys_reg_map_rollback_ctrl #(
    .LOG_ROB_DEPTH(6), .LOG_CHECKPOINT_COLUMNS(2),
    .LOG_NUM_ARCH_REGS(5), .LOG_NUM_PHYS_REGS(6)
  ) dut (
    .CLK(CLK), .RST(RST),
    .mispredict_valid(mispredict_valid), .mispredict_ready(mispredict_ready),
    .mispredict_ROB_index(mispredict_ROB_index),
    .mispredict_checkpoint_valid(mispredict_checkpoint_valid),
    .mispredict_checkpoint_column(mispredict_checkpoint_column),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_ROB_index(resolve_ROB_index),
    .resolve_checkpoint_column(resolve_checkpoint_column),
    .rob_tail_index(rob_tail_index), .rob_read_index(rob_read_index),
    .rob_read_has_dest(rob_read_has_dest),
    .rob_read_arch_reg_tag(rob_read_arch_reg_tag),
    .rob_read_safe_phys_reg_tag(rob_read_safe_phys_reg_tag),
    .rob_read_spec_phys_reg_tag(rob_read_spec_phys_reg_tag),
    .revert_valid(revert_valid),
    .revert_dest_arch_reg_tag(revert_dest_arch_reg_tag),
    .revert_safe_dest_phys_reg_tag(revert_safe_dest_phys_reg_tag),
    .revert_speculated_dest_phys_reg_tag(revert_speculated_dest_phys_reg_tag),
    .restore_checkpoint_valid(restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed(restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index(restore_checkpoint_ROB_index),
    .restore_checkpoint_safe_column(restore_checkpoint_safe_column),
    .restore_checkpoint_success(restore_checkpoint_success),
    .free_list_push_valid(free_list_push_valid),
    .free_list_push_tag(free_list_push_tag),
    .rob_rollback_valid(rob_rollback_valid),
    .rob_rollback_tail_index(rob_rollback_tail_index),
    .busy(busy)
  );

  // Clock generation.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROB contents: every entry writes a destination except entry 0.
  // arch = index[4:0], safe = index, spec = index + 32.
  logic [63:0] rob_has;
  initial rob_has = {{63{1'b1}}, 1'b0};

  // Same-cycle ROB read port model.
  always_comb begin
    rob_read_has_dest          = rob_has[rob_read_index];
    rob_read_arch_reg_tag      = rob_read_index[4:0];
    rob_read_safe_phys_reg_tag = rob_read_index;
    rob_read_spec_phys_reg_tag = rob_read_index + 6'd32;
  end

  typedef struct packed {
    logic       mv;
    logic [5:0] midx;
    logic       cv;
    logic [1:0] ccol;
    logic       rv;
    logic [5:0] ridx;
    logic [1:0] rcol;
    logic [5:0] tail;
    logic       succ;
  } vin_t;

  typedef struct packed {
    logic       mrdy;
    logic       rrdy;
    logic       busy;
    logic [5:0] rd;
    logic       revv;
    logic [4:0] reva;
    logic [5:0] revs;
    logic [5:0] revp;
    logic       rsv;
    logic       rsf;
    logic [5:0] rsi;
    logic [1:0] rsc;
    logic       puv;
    logic [5:0] put;
    logic       rbv;
    logic [5:0] rbt;
  } vexp_t;

  vin_t  tbl_in[$];
  vexp_t tbl_exp[$];
  string tbl_name[$];
  int    total;
  int    bad;

  logic [50:0] act;
  assign act = {mispredict_ready, resolve_ready, busy, rob_read_index,
                revert_valid, revert_dest_arch_reg_tag, revert_safe_dest_phys_reg_tag,
                revert_speculated_dest_phys_reg_tag, restore_checkpoint_valid,
                restore_checkpoint_speculate_failed, restore_checkpoint_ROB_index,
                restore_checkpoint_safe_column, free_list_push_valid, free_list_push_tag,
                rob_rollback_valid, rob_rollback_tail_index};

  function automatic vin_t vi(int mv, int midx, int cv, int ccol, int rv, int ridx,
                              int rcol, int tail, int succ);
    vin_t v;
    v.mv = 1'(mv); v.midx = 6'(midx); v.cv = 1'(cv); v.ccol = 2'(ccol);
    v.rv = 1'(rv); v.ridx = 6'(ridx); v.rcol = 2'(rcol); v.tail = 6'(tail);
    v.succ = 1'(succ);
    return v;
  endfunction

  function automatic vexp_t ve(int mrdy, int rrdy, int bsy, int rd, int revv, int reva,
                               int revs, int revp, int rsv, int rsf, int rsi, int rsc,
                               int puv, int put, int rbv, int rbt);
    vexp_t e;
    e.mrdy = 1'(mrdy); e.rrdy = 1'(rrdy); e.busy = 1'(bsy); e.rd = 6'(rd);
    e.revv = 1'(revv); e.reva = 5'(reva); e.revs = 6'(revs); e.revp = 6'(revp);
    e.rsv = 1'(rsv); e.rsf = 1'(rsf); e.rsi = 6'(rsi); e.rsc = 2'(rsc);
    e.puv = 1'(puv); e.put = 6'(put); e.rbv = 1'(rbv); e.rbt = 6'(rbt);
    return e;
  endfunction

  function automatic vexp_t e_idle(int rrdy);
    return ve(1, rrdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vexp_t e_walk(int rd, int revv, int a, int s, int p, int puv, int put);
    return ve(0, 0, 1, rd, revv, a, s, p, 0, 0, 0, 0, puv, put, 0, 0);
  endfunction

  function automatic vexp_t e_rest(int f, int idx, int col);
    return ve(0, 0, 1, 0, 0, 0, 0, 0, 1, f, idx, col, 0, 0, 0, 0);
  endfunction

  function automatic vexp_t e_done(int t);
    return ve(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t);
  endfunction

  task automatic add(input string nm, input vin_t i_v, input vexp_t e_v);
    tbl_name.push_back(nm);
    tbl_in.push_back(i_v);
    tbl_exp.push_back(e_v);
  endtask

  task automatic drive(input vin_t v);
    mispredict_valid             = v.mv;
    mispredict_ROB_index         = v.midx;
    mispredict_checkpoint_valid  = v.cv;
    mispredict_checkpoint_column = v.ccol;
    resolve_valid                = v.rv;
    resolve_ROB_index            = v.ridx;
    resolve_checkpoint_column    = v.rcol;
    rob_tail_index               = v.tail;
    restore_checkpoint_success   = v.succ;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    vin_t ni;
    vin_t ns;
    int   cycles;
    int   pushes;
    bit   finished;
    total = 0;
    bad   = 0;
    ni = vi(0, 0, 0, 0, 0, 0, 0, 10, 0);
    ns = vi(0, 0, 0, 0, 0, 0, 0, 10, 1);

    // Reset and idle.
    add("idle",     ni, e_idle(1));
    // No checkpoint, tail 10, branch 6: revert + free 9, 8, 7; tail -> 7.
    add("t1_acc",   vi(1, 6, 0, 0, 0, 0, 0, 10, 0), e_idle(0));
    add("t1_w9",    ni, e_walk(9, 1, 9, 9, 41, 1, 41));
    add("t1_w8",    ni, e_walk(8, 1, 8, 8, 40, 1, 40));
    add("t1_w7",    ni, e_walk(7, 1, 7, 7, 39, 1, 39));
    add("t1_done",  ni, e_done(7));
    add("t1_idle",  ni, e_idle(1));
    // Checkpoint column 2 restored successfully: frees only.
    add("t2_acc",   vi(1, 6, 1, 2, 0, 0, 0, 10, 1), e_idle(0));
    add("t2_rest",  ns, e_rest(1, 6, 2));
    add("t2_w9",    ns, e_walk(9, 0, 0, 0, 0, 1, 41));
    add("t2_w8",    ns, e_walk(8, 0, 0, 0, 0, 1, 40));
    add("t2_w7",    ns, e_walk(7, 0, 0, 0, 0, 1, 39));
    add("t2_done",  ns, e_done(7));
    add("t2_idle",  ns, e_idle(1));
    // Wrap: tail 2, branch 62 walks 1, 0 (no dest), 63; tail -> 63.
    add("t3_acc",   vi(1, 62, 0, 0, 0, 0, 0, 2, 0), e_idle(0));
    add("t3_w1",    ni, e_walk(1, 1, 1, 1, 33, 1, 33));
    add("t3_w0",    ni, e_walk(0, 0, 0, 0, 0, 0, 0));
    add("t3_w63",   ni, e_walk(63, 1, 31, 63, 31, 1, 31));
    add("t3_done",  ni, e_done(63));
    add("t3_idle",  ni, e_idle(1));
    // Checkpoint restore fails: walk reverts as well as frees.
    add("t4_acc",   vi(1, 7, 1, 0, 0, 0, 0, 10, 0), e_idle(0));
    add("t4_rest",  ni, e_rest(1, 7, 0));
    add("t4_w9",    ni, e_walk(9, 1, 9, 9, 41, 1, 41));
    add("t4_w8",    ni, e_walk(8, 1, 8, 8, 40, 1, 40));
    add("t4_done",  ni, e_done(8));
    add("t4_idle",  ni, e_idle(1));
    // Branch is youngest entry, with checkpoint: restore then straight to done.
    add("t5_acc",   vi(1, 9, 1, 1, 0, 0, 0, 10, 0), e_idle(0));
    add("t5_rest",  ni, e_rest(1, 9, 1));
    add("t5_done",  ni, e_done(10));
    add("t5_idle",  ni, e_idle(1));
    // Branch is youngest entry, no checkpoint: done on the next cycle.
    add("t6_acc",   vi(1, 9, 0, 0, 0, 0, 0, 10, 0), e_idle(0));
    add("t6_done",  ni, e_done(10));
    add("t6_idle",  ni, e_idle(1));
    // Simultaneous mispredict and resolve: resolve is refused, no invalidate.
    add("t7_acc",   vi(1, 8, 0, 0, 1, 3, 3, 10, 1), e_idle(0));
    add("t7_w9",    vi(0, 0, 0, 0, 1, 3, 3, 10, 1), e_walk(9, 1, 9, 9, 41, 1, 41));
    add("t7_done",  ni, e_done(9));
    add("t7_idle",  ni, e_idle(1));
    // Resolve at 4, column 1: one invalidate cycle, success ignored.
    add("t8_acc",   vi(0, 0, 0, 0, 1, 4, 1, 10, 0), e_idle(1));
    add("t8_inval", ns, e_rest(0, 4, 1));
    add("t8_idle",  ni, e_idle(1));

    // Reset, with a check while reset is still held.
    RST = 1'b1;
    drive(ni);
    @(negedge CLK);
    #1;
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_readies", 64'({mispredict_ready, resolve_ready}), 64'd3);
    chk("rst_valids", 64'({revert_valid, restore_checkpoint_valid, free_list_push_valid,
                           rob_rollback_valid}), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < tbl_in.size(); i++) begin
      @(negedge CLK);
      drive(tbl_in[i]);
      #1;
      chk(tbl_name[i], 64'(act), 64'(tbl_exp[i]));
    end

    // Full ROB: branch 5 with tail 5 walks 63 entries (62 with a dest).
    @(negedge CLK);
    drive(vi(1, 5, 0, 0, 0, 0, 0, 5, 0));
    #1;
    chk("full_acc_rdy", 64'(mispredict_ready), 64'd1);
    cycles   = 0;
    pushes   = 0;
    finished = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      @(negedge CLK);
      drive(ni);
      #1;
      cycles = cycles + 1;
      if (free_list_push_valid) pushes = pushes + 1;
      if (rob_rollback_valid) begin
        finished = 1'b1;
        chk("full_tail", 64'(rob_rollback_tail_index), 64'd6);
      end
    end
    chk("full_finished", 64'(finished), 64'd1);
    chk("full_cycles", 64'(cycles), 64'd64);
    chk("full_pushes", 64'(pushes), 64'd62);
    @(negedge CLK);
    #1;
    chk("full_idle_busy", 64'(busy), 64'd0);

    // Reset in the middle of a walk abandons it.
    @(negedge CLK);
    drive(vi(1, 6, 0, 0, 0, 0, 0, 10, 0));
    @(negedge CLK);
    drive(ni);
    #1;
    chk("mid_walk_push", 64'({free_list_push_valid, free_list_push_tag}), 64'h69);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("mid_rst_state", 64'({busy, free_list_push_valid, revert_valid,
                              rob_rollback_valid, mispredict_ready, resolve_ready}), 64'h3);
    @(negedge CLK);
    #1;
    chk("mid_rst_after", 64'({busy, free_list_push_valid, revert_valid,
                              rob_rollback_valid}), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phys_reg_map_rollback_ctrl.md
# phys_reg_map_rollback_ctrl

Initiator side of the physical register map table's revert/restore/invalidate interface. On a branch mispredict it restores the branch's checkpoint column when one exists. It then walks the ROB from youngest to oldest, down to the entry just younger than the branch. For each entry that wrote a destination it issues a revert (only if the restore did not succeed) and frees the speculated physical register. On a correctly resolved branch it invalidates that branch's checkpoint column. It sits in the core between branch resolution, the ROB, the free list and the map table, and stalls dispatch while active.

## Interface
- LOG_ROB_DEPTH, 6, ROB index width; ROB depth = 2^LOG_ROB_DEPTH
- LOG_CHECKPOINT_COLUMNS, 2, checkpoint column index width
- LOG_NUM_ARCH_REGS, 5, arch reg tag width
- LOG_NUM_PHYS_REGS, 6, phys reg tag width

Ports:
- CLK  in  1  clock; one clock domain
- RST  in  1  reset, synchronous, active-high
- mispredict_valid / mispredict_ready  in / out  1  mispredict handshake
- mispredict_ROB_index  in  LOG_ROB_DEPTH  ROB index of the mispredicted branch
- mispredict_checkpoint_valid  in  1  branch saved a checkpoint column
- mispredict_checkpoint_column  in  LOG_CHECKPOINT_COLUMNS  branch's safe column
- resolve_valid / resolve_ready  in / out  1  correct-resolution handshake
- resolve_ROB_index, resolve_checkpoint_column  in  LOG_ROB_DEPTH, LOG_CHECKPOINT_COLUMNS  checkpoint to invalidate
- rob_tail_index  in  LOG_ROB_DEPTH  next free ROB slot
- rob_read_index  out  LOG_ROB_DEPTH  combinational ROB read address
- rob_read_has_dest, rob_read_arch_reg_tag, rob_read_safe_phys_reg_tag, rob_read_spec_phys_reg_tag  in  1, LOG_NUM_ARCH_REGS, LOG_NUM_PHYS_REGS x2  same-cycle ROB read data
- revert_valid, revert_dest_arch_reg_tag, revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag  out  1, arch, phys, phys  to map table
- restore_checkpoint_valid, restore_checkpoint_speculate_failed  out  1, 1  to map table
- restore_checkpoint_ROB_index, restore_checkpoint_safe_column  out  LOG_ROB_DEPTH, LOG_CHECKPOINT_COLUMNS  to map table
- restore_checkpoint_success  in  1  same-cycle result from map table
- free_list_push_valid, free_list_push_tag  out  1, LOG_NUM_PHYS_REGS  free speculated register
- rob_rollback_valid, rob_rollback_tail_index  out  1, LOG_ROB_DEPTH  new ROB tail = branch index + 1
- busy  out  1  high in every state except IDLE; dispatch stalls

## Operation
- FSM states: IDLE, INVAL, RESTORE, WALK, DONE.
- IDLE: mispredict_ready = 1. resolve_ready = ~mispredict_valid, so a mispredict wins a simultaneous handshake.
- Mispredict accept: latch branch index and column. Compute walk_count = (rob_tail_index - mispredict_ROB_index - 1) mod 2^LOG_ROB_DEPTH. Load walk_ptr = rob_tail_index - 1. Clear `restored`.
  - Next state is RESTORE if checkpoint valid, else WALK (DONE if walk_count = 0).
- RESTORE, one cycle:
  - Drive restore_checkpoint_valid = 1 and speculate_failed = 1, with the latched ROB index and column.
  - Set `restored` = restore_checkpoint_success.
  - Next state is WALK, or DONE if walk_count = 0.
- WALK, one entry per cycle:
  - rob_read_index = walk_ptr.
  - If has_dest: free_list_push_valid = 1 with spec tag. If ~restored: also revert_valid = 1 with arch/safe/spec tags.
  - Decrement walk_ptr modulo depth and decrement walk_count; leave for DONE after the entry where walk_count was 1.
- DONE, one cycle: rob_rollback_valid = 1, tail = branch + 1 (mod depth); then IDLE.
- Resolve accept: latch index/column → INVAL for one cycle: restore_checkpoint_valid = 1, speculate_failed = 0; success is ignored; then IDLE.
- Full ROB: mispredict at the oldest entry with tail == branch index gives walk_count = depth - 1. All younger entries are walked.
- Outputs not driven in the current state are 0.

## Timing
- RST high at an edge: state IDLE, counters/latches 0, all valid outputs 0, busy 0, mispredict_ready / resolve_ready 1 the following cycle. Reset mid-walk abandons the walk with no further pushes.
- ROB read and map-table success are combinational in the same cycle; all handshake outputs are Moore (derived from state), except the ready signals, which also depend on mispredict_valid.
- Mispredict with checkpoint and N younger entries: restore on cycle +1, walk cycles +2 .. +N+1, rollback on cycle N+2. Without checkpoint, everything shifts one cycle earlier.
- Resolve: invalidate asserted exactly one cycle after accept.

## Test plan
- Reset, then idle: all valids 0, busy 0, both readies 1.
- Tail = 10, mispredict at 6, no checkpoint, entries 9/8/7 all has_dest → reverts 9, 8, 7 in consecutive cycles with matching free pushes; rollback tail = 7 on the next cycle.
- Same setup with checkpoint column 2 and success = 1 → restore cycle (ROB index 6, column 2), then 3 free pushes and zero reverts.
- Wrap: tail = 2, mispredict at 62 (depth 64) → walks indices 1, 0, 63; rollback tail = 63. A has_dest = 0 entry produces no push or revert.
- Mispredict and resolve in the same cycle → resolve_ready = 0 and no invalidate. After DONE, a resolve at index 4, column 1 produces one cycle of restore_checkpoint_valid = 1, speculate_failed = 0.
- Assert RST mid-WALK → next cycle idle, no pushes, busy 0.
